mem_stage_dreq: RTL and testbench

- MEM-stage data-memory requester; consumes the fields latched by the EX->MEM pipeline register and drives the SRAM-like data bus (req/addr_ok/data_ok).
- Produces `mem_stall`, which feeds back as the `stall` input of the EX->MEM pipeline register, plus aligned and extended load data for the MEM->WB path.
- Sits between the EX->MEM pipeline register and the data cache / bus bridge.

---
 rtl/mem_stage_dreq.sv | 215 +++++++++++++++++++++
 tb/tb_mem_stage_dreq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dreq.sv
// MEM-stage data-memory requester: issues SRAM-like bus requests for loads/stores,
// stalls the EX->MEM register while a request is in flight, and aligns/extends load data.
module mem_stage_dreq #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          mem_re,
    input  logic          mem_we,
    input  logic [1:0]    mem_size,
    input  logic          mem_unsigned,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          exc_kill,
    input  logic          downstream_stall,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata,
    output logic          mem_stall,
    output logic [DW-1:0] rdata_out,
    output logic          rdata_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          re_q, re_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          start_s;
    logic          capture_s;
    logic          hold_capture_s;
    logic          use_live_s;
    logic [DW-1:0] load_src_s;

    // Store data is replicated onto every byte lane so the bus only needs byte enables.
    function automatic logic [DW-1:0] lane_replicate(input logic [1:0] size, input logic [DW-1:0] wd);
        logic [DW-1:0] r;
        case (size)
            2'd0:    r = {4{wd[7:0]}};
            2'd1:    r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Halfword lane selects on addr[1] only; misalignment is reported upstream via exc_kill.
    function automatic logic [DW-1:0] load_extract(input logic [1:0] size, input logic [1:0] lo,
                                                   input logic uns, input logic [DW-1:0] word);
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        if (lo[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (size)
            2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign start_s = in_valid & (mem_re | mem_we) & ~exc_kill;

    // Next-state, request and stall generation.
    always_comb begin
        state_d        = state_q;
        data_req       = 1'b0;
        mem_stall      = 1'b0;
        capture_s      = 1'b0;
        hold_capture_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    data_req  = 1'b1;
                    mem_stall = 1'b1;
                    capture_s = 1'b1;
                    state_d   = data_addr_ok ? S_DATA : S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                data_req  = 1'b1;
                mem_stall = 1'b1;
                state_d   = data_addr_ok ? S_DATA : S_ADDR;
            end
            S_DATA: begin
                if (data_data_ok) begin
                    if (downstream_stall) begin
                        hold_capture_s = 1'b1;
                        state_d        = S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    mem_stall = 1'b1;
                end
            end
            S_HOLD: begin
                state_d = downstream_stall ? S_HOLD : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request payload is captured when the request first goes out; response word when held.
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        re_d    = re_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (capture_s) begin
            addr_d  = addr;
            size_d  = mem_size;
            uns_d   = mem_unsigned;
            re_d    = mem_re;
            wr_d    = mem_we;
            wdata_d = lane_replicate(mem_size, wdata);
        end else begin
            addr_d = addr_q;
        end
        if (hold_capture_s) begin
            rdata_d = data_rdata;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Bus payload: live inputs while idle (zero-bubble issue), held copies afterwards.
    always_comb begin
        use_live_s = (state_q == S_IDLE);
        if (use_live_s) begin
            data_addr  = addr;
            data_wr    = mem_we;
            data_size  = mem_size;
            data_wdata = lane_replicate(mem_size, wdata);
        end else begin
            data_addr  = addr_q;
            data_wr    = wr_q;
            data_size  = size_q;
            data_wdata = wdata_q;
        end
    end

    // Load result: straight from the bus on completion, from the held word in HOLD.
    always_comb begin
        if (state_q == S_HOLD) begin
            load_src_s = rdata_q;
        end else begin
            load_src_s = data_rdata;
        end
        rdata_valid = re_q & (((state_q == S_DATA) & data_data_ok) | (state_q == S_HOLD));
        if (rdata_valid) begin
            rdata_out = load_extract(size_q, addr_q[1:0], uns_q, load_src_s);
        end else begin
            rdata_out = '0;
        end
    end

    // State and capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            re_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            re_q    <= re_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_dreq.sv
// Randomized bench for mem_stage_dreq: a transaction-level script of bus latencies
// predicts every cycle's outputs from plain arithmetic on the request fields.
module tb_mem_stage_dreq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_re, mem_we, mem_unsigned, exc_kill, downstream_stall;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok, mem_stall, rdata_valid;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata, rdata_out;

    int n_vec = 0;
    int n_err = 0;

    mem_stage_dreq #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_re(mem_re), .mem_we(mem_we),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
        .exc_kill(exc_kill), .downstream_stall(downstream_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .mem_stall(mem_stall), .rdata_out(rdata_out),
        .rdata_valid(rdata_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'h0000_00FF) * 32'h0101_0101;
        else if (sz == 2'd1) return (w & 32'h0000_FFFF) * 32'h0001_0001;
        else return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [1:0] a2, input logic [31:0] rd);
        logic [31:0] v;
        int          bits;
        if (sz == 2'd0) begin
            bits = 8;
            v = (rd >> (8 * a2)) & 32'h0000_00FF;
        end else if (sz == 2'd1) begin
            bits = 16;
            v = (rd >> (16 * a2[1])) & 32'h0000_FFFF;
        end else begin
            return rd;
        end
        if (!uns && (((v >> (bits - 1)) & 32'd1) == 32'd1))
            v = v | ~((32'd1 << bits) - 32'd1);
        return v;
    endfunction

    // Inputs that the DUT must ignore once the request has been issued.
    task automatic scramble();
        in_valid     = 1'b1;
        mem_re       = 1'($urandom);
        mem_we       = 1'($urandom);
        mem_size     = 2'($urandom);
        mem_unsigned = 1'($urandom);
        addr         = $urandom;
        wdata        = $urandom;
        exc_kill     = 1'($urandom);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".req"},   32'(data_req),    32'd0);
        chk({tag, ".stall"}, 32'(mem_stall),   32'd0);
        chk({tag, ".vld"},   32'(rdata_valid), 32'd0);
        chk({tag, ".out"},   rdata_out,        32'd0);
    endtask

    // da = extra cycles before addr_ok, dd = cycles from acceptance to data_ok, hold = HOLD cycles.
    task automatic run_txn(input logic re, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int da, input int dd, input int hold, input logic kill_mid);
        logic [31:0] exp_wd, exp_out;
        exp_wd  = model_wdata(sz, wd);
        exp_out = re ? model_load(sz, uns, a[1:0], rd) : 32'd0;
        for (int c = 0; c <= da; c++) begin
            @(negedge clk);
            if (c == 0) begin
                in_valid = 1'b1; mem_re = re; mem_we = we; mem_size = sz;
                mem_unsigned = uns; addr = a; wdata = wd; exc_kill = 1'b0;
            end else begin
                scramble();
                if (kill_mid) exc_kill = 1'b1;
            end
            data_addr_ok = (c == da); data_data_ok = 1'b0;
            downstream_stall = 1'b0; data_rdata = $urandom;
            #2;
            chk("req",   32'(data_req),  32'd1);
            chk("wr",    32'(data_wr),   32'(we));
            chk("addr",  data_addr,      a);
            chk("size",  32'(data_size), 32'(sz));
            chk("wdata", data_wdata,     exp_wd);
            chk("stall", 32'(mem_stall), 32'd1);
            chk("vld_a", 32'(rdata_valid), 32'd0);
        end
        for (int c = 1; c <= dd; c++) begin
            @(negedge clk);
            scramble();
            data_addr_ok = 1'b0;
            data_data_ok = (c == dd);
            data_rdata   = (c == dd) ? rd : $urandom;
            downstream_stall = (c == dd) ? (hold > 0) : 1'($urandom);
            #2;
            chk("req_d", 32'(data_req), 32'd0);
            if (c < dd) begin
                chk("stall_d", 32'(mem_stall),   32'd1);
                chk("vld_d",   32'(rdata_valid), 32'd0);
            end else begin
                chk("stall_ok", 32'(mem_stall),   32'd0);
                chk("vld_ok",   32'(rdata_valid), 32'(re));
                chk("out_ok",   rdata_out,        exp_out);
            end
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            scramble();
            data_addr_ok = 1'($urandom); data_data_ok = 1'($urandom);
            data_rdata = $urandom; downstream_stall = (h < hold);
            #2;
            chk("req_h",   32'(data_req),    32'd0);
            chk("stall_h", 32'(mem_stall),   32'd0);
            chk("vld_h",   32'(rdata_valid), 32'(re));
            chk("out_h",   rdata_out,        exp_out);
        end
    endtask

    // A cycle with no legal start: nothing killed or absent may reach the bus.
    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'($urandom); mem_re = 1'($urandom); mem_we = 1'($urandom);
        exc_kill = in_valid ? 1'b1 : 1'($urandom);
        mem_size = 2'($urandom); addr = $urandom; wdata = $urandom;
        data_addr_ok = 1'($urandom); data_data_ok = 1'($urandom);
        downstream_stall = 1'($urandom); data_rdata = $urandom;
        #2;
        chk_quiet("idle");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mem_re = 1'b0; mem_we = 1'b0; mem_size = 2'd0;
        mem_unsigned = 1'b0; addr = 32'd0; wdata = 32'd0; exc_kill = 1'b0;
        downstream_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #2;
        chk_quiet("rst");
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_quiet("post_rst");

        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'd0, 32'h8899_AABB, 0, 1, 0, 1'b0);
        run_txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 32'h8011_2233, 0, 1, 0, 1'b0);
        run_txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 32'h8011_2233, 0, 1, 0, 1'b0);
        run_txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_1002, 32'd0, 32'h8011_2233, 0, 1, 0, 1'b0);
        run_txn(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h0000_00A5, 32'd0, 3, 1, 0, 1'b0);
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'd0, 32'hDEAD_BEEF, 0, 1, 2, 1'b0);

        @(negedge clk);
        in_valid = 1'b1; mem_re = 1'b1; mem_we = 1'b0; exc_kill = 1'b1;
        data_addr_ok = 1'b1; data_data_ok = 1'b0; downstream_stall = 1'b0;
        #2;
        chk_quiet("kill_idle");
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_4004, 32'd0, 32'h1234_5678, 2, 2, 0, 1'b1);

        // Reset while waiting for data_ok; the late data_ok must be ignored.
        @(negedge clk);
        in_valid = 1'b1; mem_re = 1'b1; mem_we = 1'b0; exc_kill = 1'b0; mem_size = 2'd2;
        addr = 32'h0000_5000; data_addr_ok = 1'b1; data_data_ok = 1'b0;
        #2;
        chk("rst_txn.req", 32'(data_req), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; data_addr_ok = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        #2;
        chk_quiet("late_ok");
        @(negedge clk);
        data_data_ok = 1'b0;
        #2;
        chk_quiet("after_late");

        for (int t = 0; t < 200; t++) begin
            logic re;
            re = 1'($urandom);
            if ($urandom_range(3, 0) == 0) idle_cycle();
            run_txn(re, ~re, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(3, 0)), int'($urandom_range(3, 1)),
                    int'($urandom_range(2, 0)), 1'($urandom));
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
